// File: rtl/tetris_soc_usb_gpx_cond.sv
// GPX pin conditioner: 2-flop sync, glitch filter, edge capture,
// Avalon-MM register slave and maskable level interrupt.
module tetris_soc_usb_gpx_cond #(
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gpx_pin,
  output logic        gpx_clean,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam logic [7:0] CNT_MAX = 8'(FILTER_CYCLES - 1);

  logic        s1_q, s2_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        clean_q, clean_d;
  logic [1:0]  mask_q, mask_d;
  logic [1:0]  ec_q, ec_d;
  logic [31:0] rdata_q, rdata_d;

  logic       wr, upd;
  logic [1:0] clr, setb;
  logic       unused_wdata;

  assign unused_wdata = ^writedata[31:2];

  assign wr  = chipselect && !write_n;
  assign upd = (s2_q != clean_q) && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (s2_q == clean_q) cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = '0;
  end

  assign clean_d = upd ? s2_q : clean_q;
  assign setb    = {upd && !s2_q, upd && s2_q};

  assign mask_d = (wr && address == 2'd1) ? writedata[1:0] : mask_q;
  assign clr    = (wr && address == 2'd3) ? writedata[1:0] : 2'b00;
  // A set event in the same cycle as a clear keeps the bit set
  assign ec_d   = (ec_q & ~clr) | setb;

  always_comb begin
    rdata_d = '0;
    unique case (address)
      2'd0: rdata_d[0]   = clean_q;
      2'd1: rdata_d[1:0] = mask_q;
      2'd2: rdata_d      = '0;
      2'd3: rdata_d[1:0] = ec_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      mask_q  <= '0;
      ec_q    <= '0;
      rdata_q <= '0;
    end else begin
      s1_q    <= gpx_pin;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      mask_q  <= mask_d;
      ec_q    <= ec_d;
      rdata_q <= rdata_d;
    end
  end

  assign gpx_clean = clean_q;
  assign readdata  = rdata_q;
  assign irq       = |(ec_q & mask_q);

endmodule

// File: tb/tb_tetris_soc_usb_gpx_cond.sv
// Randomized and directed bench for the GPX conditioner,
// checked against a run-length reference model.
module tb_tetris_soc_usb_gpx_cond;

  localparam int FC = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        gpx_pin = 1'b0;
  logic        gpx_clean;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;

  int n_chk = 0;
  int n_pass = 0;

  // reference model state
  bit         pipe[$];
  bit         clean_m;
  int         run_m;
  bit [1:0]   mask_m, ec_m;
  bit [31:0]  rd_m;

  tetris_soc_usb_gpx_cond #(.FILTER_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .gpx_pin(gpx_pin),
    .gpx_clean(gpx_clean), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    pipe = '{1'b0, 1'b0};
    clean_m = 0; run_m = 0; mask_m = 0; ec_m = 0; rd_m = 0;
  endtask

  function automatic bit upd_pending();
    return pipe[0] != clean_m && run_m == FC - 1;
  endfunction

  task automatic model_edge(input bit pin, input bit wr,
                            input bit [1:0] a, input bit [31:0] wd);
    bit s2;
    bit [1:0] setb, clr;
    case (a)
      2'd0: rd_m = {31'd0, clean_m};
      2'd1: rd_m = {30'd0, mask_m};
      2'd2: rd_m = 32'd0;
      default: rd_m = {30'd0, ec_m};
    endcase
    s2 = pipe[0];
    setb = 0;
    if (s2 == clean_m) run_m = 0;
    else begin
      run_m++;
      if (run_m == FC) begin
        clean_m = s2;
        run_m = 0;
        setb = s2 ? 2'b01 : 2'b10;
      end
    end
    pipe.push_back(pin);
    void'(pipe.pop_front());
    clr = (wr && a == 2'd3) ? wd[1:0] : 2'b00;
    if (wr && a == 2'd1) mask_m = wd[1:0];
    ec_m = (ec_m & ~clr) | setb;
  endtask

  task automatic step(input bit pin, input bit wr,
                      input bit [1:0] a, input bit [31:0] wd);
    gpx_pin = pin;
    chipselect = wr ? 1'b1 : ($urandom_range(0, 1) == 1);
    write_n = !wr;
    address = a;
    writedata = wd;
    @(posedge clk);
    model_edge(pin, wr, a, wd);
    #1;
    check("clean", {31'd0, gpx_clean}, {31'd0, clean_m});
    check("irq", {31'd0, irq}, {31'd0, |(ec_m & mask_m)});
    check("readdata", readdata, rd_m);
  endtask

  task automatic rd(input bit pin, input bit [1:0] a);
    step(pin, 1'b0, a, $urandom);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < cycles; i++) begin
      gpx_pin = ~gpx_pin;
      check("rst_clean", {31'd0, gpx_clean}, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_rdata", readdata, 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    // reset with toggling pin
    do_reset(4);
    gpx_pin = 1'b0;
    rd(0, 2'd1);
    check("rst_mask_rd", readdata, 32'd0);
    rd(0, 2'd3);
    check("rst_ec_rd", readdata, 32'd0);
    for (int i = 0; i < 4; i++) rd(0, 2'd0);

    // clean rise with mask = 1
    step(0, 1, 2'd1, 32'h1);
    for (int i = 0; i < 8; i++) begin
      rd(1, 2'd3);
      if (i == 4) check("rise_pre", {31'd0, gpx_clean}, 32'd0);
      if (i == 5) begin
        check("rise_lat", {31'd0, gpx_clean}, 32'd1);
        check("rise_irq", {31'd0, irq}, 32'd1);
      end
    end
    check("rise_ec", readdata, 32'h1);

    // glitch rejection
    for (int i = 0; i < 8; i++) rd(0, 2'd0);
    step(0, 1, 2'd3, 32'h3);
    for (int i = 0; i < 3; i++) rd(1, 2'd0);
    for (int i = 0; i < 8; i++) begin
      rd(0, 2'd3);
      check("glitch_clean", {31'd0, gpx_clean}, 32'd0);
    end
    check("glitch_ec", readdata, 32'd0);
    for (int i = 0; i < 4; i++) rd(1, 2'd0);
    for (int i = 0; i < 6; i++) begin
      rd(0, 2'd0);
      if (i == 4) check("fall_pre", {31'd0, gpx_clean}, 32'd1);
      if (i == 5) check("fall_lat", {31'd0, gpx_clean}, 32'd0);
    end
    rd(0, 2'd3);
    check("pulse_ec", readdata, 32'h3);

    // W1C and set/clear collision
    step(0, 1, 2'd3, 32'h3);
    step(0, 1, 2'd1, 32'h3);
    for (int i = 0; i < 8; i++) rd(1, 2'd0);
    step(1, 1, 2'd3, 32'h1);
    check("w1c_irq", {31'd0, irq}, 32'd0);
    rd(1, 2'd3);
    check("w1c_ec", readdata, 32'd0);
    begin
      bit hit = 0;
      for (int i = 0; i < 12 && !hit; i++) begin
        if (upd_pending()) begin
          hit = 1;
          step(0, 1, 2'd3, 32'h2);
          check("collide_irq", {31'd0, irq}, 32'd1);
        end else rd(0, 2'd0);
      end
      check("collide_seen", {31'd0, hit}, 32'd1);
    end
    rd(0, 2'd3);
    check("collide_ec", readdata, 32'h2);

    // reset mid-filter
    for (int i = 0; i < 8; i++) rd(0, 2'd0);
    begin
      bit hit = 0;
      for (int i = 0; i < 12 && !hit; i++) begin
        rd(1, 2'd0);
        if (run_m == 2) hit = 1;
      end
      check("midrst_cnt2", {31'd0, hit}, 32'd1);
    end
    do_reset(3);
    for (int i = 0; i < 7; i++) begin
      rd(1, 2'd3);
      if (i == 4) check("midrst_pre", {31'd0, gpx_clean}, 32'd0);
      if (i == 5) check("midrst_lat", {31'd0, gpx_clean}, 32'd1);
    end
    check("midrst_ec", readdata, 32'h1);

    // register readback
    step(1, 1, 2'd1, 32'hFFFF_FFFF);
    rd(1, 2'd1);
    check("rb_mask", readdata, 32'h3);
    rd(1, 2'd2);
    check("rb_rsvd", readdata, 32'h0);
    rd(1, 2'd0);
    check("rb_clean", readdata, 32'h1);

    // randomized soak
    begin
      bit lvl = 0;
      int hold = 0;
      for (int n = 0; n < 2000; n++) begin
        if (hold == 0) begin
          lvl = ~lvl;
          hold = $urandom_range(1, 8);
        end
        hold--;
        if ($urandom_range(0, 9) < 3)
          step(lvl, 1, 2'($urandom_range(0, 3)), $urandom);
        else
          rd(lvl, 2'($urandom_range(0, 3)));
        if ($urandom_range(0, 499) == 0) begin
          do_reset($urandom_range(1, 3));
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tetris_soc_usb_gpx_cond.md
# tetris_soc_usb_gpx_cond

Input conditioner for the USB controller's asynchronous GPX pin, sitting directly upstream of the GPX PIO input port. It synchronizes the raw pin and rejects glitches shorter than a programmable filter length. It drives the clean level on `gpx_clean`, which feeds the PIO `in_port`. It also captures filtered rising and falling edges into an Avalon-MM slave register and raises a maskable interrupt, so software need not poll.

## Interface

- `FILTER_CYCLES`, default 4: consecutive synchronized cycles a new level must hold before `gpx_clean` follows; legal range 1..255.

- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `gpx_pin`  in  1  raw USB GPX pin, asynchronous to `clk`.
- `gpx_clean`  out  1  filtered level, to GPX PIO `in_port`.
- `address`  in  2  Avalon-MM word address.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data.
- `irq`  out  1  level interrupt, active-high.

## Operation

- Synchronizer: two flops `s1` and `s2`, both reset to 0. Only `s2` is used downstream.
- Filter:
  - 8-bit counter `cnt`, reset 0.
  - If `s2 == gpx_clean`: `cnt <= 0`.
  - Else if `cnt == FILTER_CYCLES-1`: `gpx_clean <= s2` and `cnt <= 0`. This is the update event.
  - Else: `cnt <= cnt + 1`.
  - Any cycle where `s2` returns to `gpx_clean` restarts the count.
- Edge capture, 2 bits:
  - `ec[0]` sets on an update event where `gpx_clean` goes 0→1.
  - `ec[1]` sets on an update event where `gpx_clean` goes 1→0.
  - Bits are sticky until cleared.
- Register map. Read bits not listed return 0.
  - addr 0: bit0 = `gpx_clean`. Read-only; writes ignored.
  - addr 1: `mask[1:0]`, read/write. Bit0 enables the rising-edge irq, bit1 the falling-edge irq.
  - addr 2: reserved. Reads 0; writes ignored.
  - addr 3: `ec[1:0]`, write-1-to-clear per bit.
- Writes occur when `chipselect && !write_n`, and take effect at that clock edge.
- `irq = |(ec & mask)`, combinational from registers.
- Simultaneous clear-write and set event on the same `ec` bit: set wins, and the bit stays 1.
- Reset mid-operation:
  - `s1`, `s2`, `cnt`, `gpx_clean`, `mask` and `ec` all clear immediately.
  - The filter restarts from `gpx_clean = 0`.
  - If the pin is high at release, a full filter pass occurs and `ec[0]` sets.

## Timing

- Reset values: `gpx_clean` = 0, `readdata` = 0x00000000, `irq` = 0.
- Pin-to-clean latency:
  - The pin level is stable from rising edge k.
  - `gpx_clean` updates at edge k+1+`FILTER_CYCLES`, i.e. `FILTER_CYCLES`+2 edges in total.
  - With the default of 4, that is 6 edges.
- Minimum accepted pulse: `FILTER_CYCLES` consecutive `s2` samples. Shorter pulses produce no change and no capture.
- `ec` bit sets at the same edge `gpx_clean` updates. `irq` is valid in the same cycle.
- Reads:
  - `readdata` is registered on every edge from the `address` mux, regardless of `chipselect`.
  - Read latency is 1 cycle.
  - A write is visible in `readdata` on the next read, with no later than 1 cycle additional delay.
- Clearing `ec` via addr 3: `irq` deasserts the cycle after the write edge, unless a set event occurred at that edge.
- The counter never exceeds `FILTER_CYCLES-1`, so no wrap is possible.

## Test plan

- Reset check: assert `reset` with `gpx_pin` toggling. Required: `gpx_clean` = 0, `irq` = 0, `readdata` = 0x0, and reads of addr 1 and addr 3 return 0x0 after release.
- Clean rise, `FILTER_CYCLES` = 4, mask = 0x1: drive `gpx_pin` 0→1 before edge k. Required:
  - `gpx_clean` = 1 at edge k+5.
  - addr 3 reads 0x00000001.
  - `irq` = 1 in the same cycle as `gpx_clean` rises.
- Glitch rejection, `FILTER_CYCLES` = 4: drive a 3-cycle high pulse, then a 4-cycle high pulse. Required:
  - The first pulse causes no `gpx_clean` change and `ec` = 0.
  - The second pulse makes `gpx_clean` rise, then fall 6 edges after the pin falls.
  - `ec` = 0x3.
- W1C and collision, mask = 0x3, `ec` = 0x1, `gpx_clean` = 1:
  - Write 0x1 to addr 3. Required: `ec` = 0 and `irq` = 0 next cycle.
  - Set `ec` = 0x2, then write 0x2 to addr 3 at the same edge as a falling update event. Required: `ec[1]` stays 1 and `irq` stays 1.
- Reset mid-filter: hold the pin high, assert `reset` when `cnt` = 2, release 3 cycles later. Required: `gpx_clean` = 0 during reset, then rises exactly 6 edges after the first post-reset edge, with `ec` = 0x1.
- Register readback: write 0xFFFFFFFF to addr 1, then read addr 1, addr 2 and addr 0. Required: 0x00000003, then 0x00000000, then 0x00000000 (or 0x00000001 when `gpx_clean` = 1), each 1 cycle after the address is presented.
